// File: rtl/image_write_ctrl_pkg.sv
// img_pkg: shared FSM states, pixel-pair layout and counter sizing for image_write_ctrl
package img_pkg;
  localparam int PIX_PAIR_W = 48;
  typedef enum logic [2:0] {S_IDLE, S_START_WAIT, S_ACTIVE, S_HBLANK, S_DONE} state_t;
  typedef struct packed {
    logic [7:0] r0;
    logic [7:0] g0;
    logic [7:0] b0;
    logic [7:0] r1;
    logic [7:0] g1;
    logic [7:0] b1;
  } pix_pair_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/image_write_ctrl_if.sv
// image_write_ctrl_if: pixel-pair stream in (in_valid/in_ready/in_pix) and writer beats out (hsync, DATA_WRITE_*, row, col); master = controller, slave = source/writer side
interface image_write_ctrl_if #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
);
  localparam int CW = $clog2(WIDTH / 2);
  localparam int RW = $clog2(HEIGHT);
  logic                            in_valid;
  logic                            in_ready;
  logic [img_pkg::PIX_PAIR_W-1:0]  in_pix;
  logic                            hsync;
  logic [7:0]                      DATA_WRITE_R0;
  logic [7:0]                      DATA_WRITE_G0;
  logic [7:0]                      DATA_WRITE_B0;
  logic [7:0]                      DATA_WRITE_R1;
  logic [7:0]                      DATA_WRITE_G1;
  logic [7:0]                      DATA_WRITE_B1;
  logic [RW-1:0]                   row;
  logic [CW-1:0]                   col;
  modport master (
    input  in_valid, in_pix,
    output in_ready, hsync, DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
           DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1, row, col
  );
  modport slave (
    output in_valid, in_pix,
    input  in_ready, hsync, DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
           DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1, row, col
  );
endinterface

// File: rtl/image_write_ctrl_pos_counter.sv
// img_pos_counter: pair column/row position of the next transfer (clk, rst, adv in; col, row, last_in_row, last_in_frame out), wrapping at row and frame end
module img_pos_counter #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        adv,
  output logic [$clog2(WIDTH/2)-1:0]  col,
  output logic [$clog2(HEIGHT)-1:0]   row,
  output logic                        last_in_row,
  output logic                        last_in_frame
);
  localparam int CW = $clog2(WIDTH / 2);
  localparam int RW = $clog2(HEIGHT);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  assign last_in_row   = col_q == CW'(WIDTH / 2 - 1);
  assign last_in_frame = last_in_row && row_q == RW'(HEIGHT - 1);
  assign col = col_q;
  assign row = row_q;
  always_comb begin
    col_d = adv ? (last_in_row ? '0 : col_q + 1'b1) : col_q;
    row_d = (adv && last_in_row) ? (last_in_frame ? '0 : row_q + 1'b1) : row_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/image_write_ctrl.sv
// image_write_ctrl: frame sequencer replaying a pixel-pair stream as hsync beats with start delay and row blanking; ports HCLK, HRESET, start, bus (image_write_ctrl_if.master), busy, frame_done, frame_count (live only with IMG_WR_CTRL_FRAME_COUNT_EN)
module image_write_ctrl
  import img_pkg::*;
#(
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  parameter int HBLANK      = 160,
  parameter int START_DELAY = 100
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                start,
  image_write_ctrl_if.master  bus,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_count
);
  localparam int CW = $clog2(WIDTH / 2);
  localparam int RW = $clog2(HEIGHT);
  localparam int DW = cnt_w((HBLANK > START_DELAY) ? HBLANK : START_DELAY);
  state_t        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          hsync_q, hsync_d;
  pix_pair_t     pix_q, pix_d;
  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic          frame_done_q, frame_done_d;
  logic          last_in_row, last_in_frame, xfer;
  img_pos_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_pos (
    .clk          (HCLK),
    .rst          (HRESET),
    .adv          (xfer),
    .col          (pos_col),
    .row          (pos_row),
    .last_in_row  (last_in_row),
    .last_in_frame(last_in_frame)
  );
  assign bus.in_ready = state_q == S_ACTIVE;
  assign xfer         = bus.in_ready & bus.in_valid;
  assign busy         = state_q != S_IDLE;
  assign frame_done   = frame_done_q;
  assign bus.hsync         = hsync_q;
  assign bus.DATA_WRITE_R0 = pix_q.r0;
  assign bus.DATA_WRITE_G0 = pix_q.g0;
  assign bus.DATA_WRITE_B0 = pix_q.b0;
  assign bus.DATA_WRITE_R1 = pix_q.r1;
  assign bus.DATA_WRITE_G1 = pix_q.g1;
  assign bus.DATA_WRITE_B1 = pix_q.b1;
  assign bus.row           = row_q;
  assign bus.col           = col_q;
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = (START_DELAY == 0) ? S_ACTIVE : S_START_WAIT;
        dly_d   = DW'(START_DELAY - 1);
      end
      S_START_WAIT, S_HBLANK: begin
        state_d = (dly_q == '0) ? S_ACTIVE : state_q;
        dly_d   = (dly_q == '0) ? dly_q : dly_q - 1'b1;
      end
      S_ACTIVE: if (xfer && last_in_frame) state_d = S_DONE;
        else if (xfer && last_in_row && HBLANK != 0) begin
          state_d = S_HBLANK;
          dly_d   = DW'(HBLANK - 1);
        end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    hsync_d      = xfer;
    pix_d        = xfer ? pix_pair_t'(bus.in_pix) : pix_q;
    col_d        = xfer ? pos_col : col_q;
    row_d        = xfer ? pos_row : row_q;
    frame_done_d = state_q == S_DONE;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      dly_q        <= '0;
      hsync_q      <= 1'b0;
      pix_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      hsync_q      <= hsync_d;
      pix_q        <= pix_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end
`ifdef IMG_WR_CTRL_FRAME_COUNT_EN
  logic [15:0] fc_q, fc_d;
  assign fc_d        = (state_q == S_DONE && fc_q != 16'hFFFF) ? fc_q + 16'd1 : fc_q;
  assign frame_count = fc_q;
  always_ff @(posedge HCLK) begin
    if (HRESET) fc_q <= '0;
    else        fc_q <= fc_d;
  end
`else
  assign frame_count = '0;
`endif
endmodule

// File: tb/tb_image_write_ctrl.sv
// tb_image_write_ctrl: directed bench for image_write_ctrl with a frame-timing model checked every cycle on two configurations
module tb_image_write_ctrl;
  localparam int W = 8;
  localparam int H = 4;
  localparam int PAIRS = W / 2;
  localparam int TOTAL = W * H / 2;
`ifdef IMG_WR_CTRL_FRAME_COUNT_EN
  localparam int FC_EN = 1;
`else
  localparam int FC_EN = 0;
`endif
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [47:0] in_pix = '0;
  int          cyc = 0;
  int          vectors = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int HB = (g == 0) ? 3 : 0;
    localparam int SD = (g == 0) ? 2 : 0;
    image_write_ctrl_if #(.WIDTH(W), .HEIGHT(H)) bus ();
    logic        busy, frame_done;
    logic [15:0] frame_count;
    assign bus.in_valid = in_valid;
    assign bus.in_pix   = in_pix;
    image_write_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB), .START_DELAY(SD)) dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_count(frame_count)
    );
    int          t = 0, rdy_at = 0, n = 0, done_at = -1, e_row = 0, e_col = 0, e_fc = 0;
    bit          run = 0, e_rdy = 0, e_hs = 0, e_done = 0;
    logic [47:0] e_pix = '0;
    always @(posedge HCLK) begin
      t = t + 1;
      if (HRESET) begin
        run = 0; n = 0; e_hs = 0; e_pix = '0; e_row = 0; e_col = 0;
        e_done = 0; e_fc = 0; done_at = -1;
      end else begin
        e_hs = e_rdy && in_valid;
        if (e_hs) begin
          e_pix = in_pix;
          e_row = n / PAIRS;
          e_col = n % PAIRS;
          n = n + 1;
          if (n == TOTAL) done_at = t + 1;
          else if (n % PAIRS == 0) rdy_at = t + HB;
        end
        if (!run && start) begin
          run = 1;
          rdy_at = t + SD;
        end
        e_done = (t == done_at);
        if (e_done) begin
          run = 0;
          n = 0;
          if (FC_EN != 0 && e_fc < 65535) e_fc = e_fc + 1;
        end
      end
      e_rdy = run && t >= rdy_at && n < TOTAL;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic cmp(input string p, input logic [71:0] a, input logic [71:0] e);
    chk({p, ".in_ready"}, a[71], e[71]);
    chk({p, ".busy"}, a[70], e[70]);
    chk({p, ".hsync"}, a[69], e[69]);
    chk({p, ".frame_done"}, a[68], e[68]);
    chk({p, ".frame_count"}, a[67:52], e[67:52]);
    chk({p, ".data"}, a[51:4], e[51:4]);
    chk({p, ".row"}, a[3:2], e[3:2]);
    chk({p, ".col"}, a[1:0], e[1:0]);
  endtask
  always @(negedge HCLK) if (chk_en) begin
    cmp("A", {u[0].bus.in_ready, u[0].busy, u[0].bus.hsync, u[0].frame_done, u[0].frame_count,
              u[0].bus.DATA_WRITE_R0, u[0].bus.DATA_WRITE_G0, u[0].bus.DATA_WRITE_B0,
              u[0].bus.DATA_WRITE_R1, u[0].bus.DATA_WRITE_G1, u[0].bus.DATA_WRITE_B1,
              u[0].bus.row, u[0].bus.col},
             {u[0].e_rdy, u[0].run, u[0].e_hs, u[0].e_done, 16'(u[0].e_fc), u[0].e_pix,
              2'(u[0].e_row), 2'(u[0].e_col)});
    cmp("B", {u[1].bus.in_ready, u[1].busy, u[1].bus.hsync, u[1].frame_done, u[1].frame_count,
              u[1].bus.DATA_WRITE_R0, u[1].bus.DATA_WRITE_G0, u[1].bus.DATA_WRITE_B0,
              u[1].bus.DATA_WRITE_R1, u[1].bus.DATA_WRITE_G1, u[1].bus.DATA_WRITE_B1,
              u[1].bus.row, u[1].bus.col},
             {u[1].e_rdy, u[1].run, u[1].e_hs, u[1].e_done, 16'(u[1].e_fc), u[1].e_pix,
              2'(u[1].e_row), 2'(u[1].e_col)});
  end
  task automatic step;
    @(posedge HCLK);
    #1;
  endtask
  task automatic run_frame(input bit kick, input bit tog, input bit rep, input int limit,
                           output int beats, output int dones, output int last, output int dc,
                           output bit idle);
    beats = 0; dones = 0; last = -1; dc = -1; idle = 0;
    for (int i = 0; i < 200 && dones == 0 && beats < limit; i++) begin
      if (tog) in_valid = ~in_valid;
      start  = (kick && i == 0) || (rep && i % 5 == 4 && beats < 14);
      in_pix = {6{8'(cyc)}} ^ 48'h0011_2233_4455;
      step;
      if (u[0].bus.hsync) begin beats++; last = cyc; end
      if (u[0].frame_done) begin dones++; dc = cyc; idle = !u[0].busy; end
    end
    start = 0;
    chk("frame_bound", (dones > 0 || beats >= limit), 1);
  endtask
  task automatic idle_check(input string p, input int cycles);
    int d = 0, b = 0;
    for (int i = 0; i < cycles; i++) begin
      step;
      d += int'(u[0].frame_done);
      b += int'(u[0].busy);
    end
    chk({p, ".extra_done"}, d, 0);
    chk({p, ".busy_after"}, b, 0);
  endtask
  initial begin
    int  beats, dones, last, dc;
    bit  idle;
    step;
    chk_en = 1;
    step; step;
    HRESET = 0;
    step;
    chk("rst.busy", u[0].busy, 0);
    chk("rst.in_ready", u[0].bus.in_ready, 0);
    chk("rst.hsync", u[0].bus.hsync, 0);
    chk("rst.frame_count", u[0].frame_count, 0);
    in_pix = 48'h0102030A0B0C; in_valid = 1; start = 1;
    step;
    start = 0;
    chk("p1.ready_c1", u[0].bus.in_ready, 0);
    step;
    chk("p1.ready_c2", u[0].bus.in_ready, 0);
    step;
    chk("p1.ready_c3", u[0].bus.in_ready, 1);
    step;
    chk("p1.hsync", u[0].bus.hsync, 1);
    chk("p1.R0", u[0].bus.DATA_WRITE_R0, 8'h01);
    chk("p1.G0", u[0].bus.DATA_WRITE_G0, 8'h02);
    chk("p1.B0", u[0].bus.DATA_WRITE_B0, 8'h03);
    chk("p1.R1", u[0].bus.DATA_WRITE_R1, 8'h0A);
    chk("p1.G1", u[0].bus.DATA_WRITE_G1, 8'h0B);
    chk("p1.B1", u[0].bus.DATA_WRITE_B1, 8'h0C);
    chk("p1.row", u[0].bus.row, 0);
    chk("p1.col", u[0].bus.col, 0);
    run_frame(0, 0, 0, 999, beats, dones, last, dc, idle);
    chk("p1.beats", beats + 1, 16);
    chk("p1.dones", dones, 1);
    chk("p1.done_after_last", dc - last, 1);
    chk("p1.busy_fall", idle, 1);
    in_valid = 1;
    run_frame(1, 1, 0, 999, beats, dones, last, dc, idle);
    chk("p2.beats", beats, 16);
    chk("p2.dones", dones, 1);
    in_valid = 1;
    run_frame(1, 0, 1, 999, beats, dones, last, dc, idle);
    chk("p3.beats", beats, 16);
    chk("p3.dones", dones, 1);
    idle_check("p3", 6);
    in_valid = 1;
    run_frame(1, 0, 0, 6, beats, dones, last, dc, idle);
    chk("p4.beats_before_rst", beats, 6);
    HRESET = 1;
    step;
    HRESET = 0;
    chk("p4.hsync", u[0].bus.hsync, 0);
    chk("p4.busy", u[0].busy, 0);
    chk("p4.in_ready", u[0].bus.in_ready, 0);
    chk("p4.row", u[0].bus.row, 0);
    chk("p4.col", u[0].bus.col, 0);
    chk("p4.R0", u[0].bus.DATA_WRITE_R0, 0);
    chk("p4.B1", u[0].bus.DATA_WRITE_B1, 0);
    chk("p4.frame_done", u[0].frame_done, 0);
    idle_check("p4", 4);
    run_frame(1, 0, 0, 999, beats, dones, last, dc, idle);
    chk("p4.refill_beats", beats, 16);
    chk("p4.refill_dones", dones, 1);
    HRESET = 1;
    step;
    HRESET = 0;
    step;
    run_frame(1, 0, 0, 999, beats, dones, last, dc, idle);
    chk("p5.B_fc1", u[1].frame_count, FC_EN);
    chk("p5.A_fc1", u[0].frame_count, FC_EN);
    run_frame(1, 0, 0, 999, beats, dones, last, dc, idle);
    chk("p5.B_fc2", u[1].frame_count, 2 * FC_EN);
    chk("p5.A_fc2", u[0].frame_count, 2 * FC_EN);
    in_valid = 0;
    step; step;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
